// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake
// Single-cycle logic/arith ops, bit-serial shifts and shift-add multiply.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] H,
  output logic             C,
  output logic             N,
  output logic             V,
  output logic             Z
);
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_CPL  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_GT   = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_ASR  = 4'd14;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] w_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] f_q, h_q;
  logic             c_q, n_q, v_q, z_q, out_valid_q;

  // The acceptance edge already performs the first step, so the step
  // datapath reads the live inputs in IDLE and the work registers in EXEC.
  logic             in_exec;
  logic [3:0]       st_op;
  logic [WIDTH-1:0] st_w, st_lo, st_b;

  assign in_exec = (state_q == EXEC);
  assign st_op   = in_exec ? op_q : FS;
  assign st_w    = in_exec ? w_q  : ((FS == OP_MUL) ? '0 : A);
  assign st_lo   = in_exec ? lo_q : A;
  assign st_b    = in_exec ? b_q  : B;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] w_d, lo_d;
  logic             sc_d;

  always_comb begin
    mul_sum = {1'b0, st_w} + (st_lo[0] ? {1'b0, st_b} : '0);
    w_d     = st_w;
    lo_d    = st_lo;
    sc_d    = 1'b0;
    case (st_op)
      OP_SHR: begin sc_d = st_w[0];       w_d = {1'b0, st_w[WIDTH-1:1]};        end
      OP_ASR: begin sc_d = st_w[0];       w_d = {st_w[WIDTH-1], st_w[WIDTH-1:1]}; end
      OP_SHL: begin sc_d = st_w[WIDTH-1]; w_d = {st_w[WIDTH-2:0], 1'b0};        end
      OP_MUL: begin
        w_d  = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], st_lo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] f_d, h_d;
  logic             c_d, v_d;

  always_comb begin
    sum = '0;
    f_d = '0;
    h_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    if (in_exec) begin
      if (op_q == OP_MUL) begin
        f_d = lo_d;
        h_d = w_d;
        c_d = |w_d;
        v_d = |w_d;
      end else begin
        f_d = w_d;
        c_d = sc_d;
      end
    end else begin
      case (FS)
        OP_ADD: begin
          sum = {1'b0, A} + {1'b0, B};
          f_d = sum[WIDTH-1:0];
          c_d = sum[WIDTH];
          v_d = (A[WIDTH-1] == B[WIDTH-1]) && (f_d[WIDTH-1] != A[WIDTH-1]);
        end
        OP_SUB: begin
          sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
          f_d = sum[WIDTH-1:0];
          c_d = sum[WIDTH];
          v_d = (A[WIDTH-1] != B[WIDTH-1]) && (f_d[WIDTH-1] != A[WIDTH-1]);
        end
        OP_XOR:         f_d = A ^ B;
        OP_OR:          f_d = A | B;
        OP_AND:         f_d = A & B;
        OP_CPL, OP_NOT: f_d = ~A;
        OP_PASS:        f_d = A;
        OP_GT:          f_d = {{(WIDTH-1){1'b0}}, (A > B)};
        OP_EQ:          f_d = {{(WIDTH-1){1'b0}}, (A == B)};
        OP_SHR, OP_SHL, OP_ASR: begin
          if (sh == '0) begin
            f_d = A;
          end else begin
            f_d = w_d;
            c_d = sc_d;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      w_q         <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      f_q         <= '0;
      h_q         <= '0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= FS;
            b_q  <= B;
            w_q  <= w_d;
            lo_q <= lo_d;
            if (FS == OP_MUL) begin
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= EXEC;
            end else if ((FS == OP_SHR || FS == OP_SHL || FS == OP_ASR) && (sh > SHW'(1))) begin
              cnt_q   <= CW'(sh) - CW'(1);
              state_q <= EXEC;
            end else begin
              f_q         <= f_d;
              h_q         <= h_d;
              c_q         <= c_d;
              v_q         <= v_d;
              n_q         <= f_d[WIDTH-1];
              z_q         <= ~|{h_d, f_d};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        EXEC: begin
          w_q   <= w_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            f_q         <= f_d;
            h_q         <= h_d;
            c_q         <= c_d;
            v_q         <= v_d;
            n_q         <= f_d[WIDTH-1];
            z_q         <= ~|{h_d, f_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign F         = f_q;
  assign H         = h_q;
  assign C         = c_q;
  assign N         = n_q;
  assign V         = v_q;
  assign Z         = z_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc
// Random and directed requests checked against an arithmetic reference model.
module tb_alu_mc;
  localparam int W    = 8;
  localparam int SW   = $clog2(W);
  localparam int SMAX = (1 << (W-1)) - 1;
  localparam int SMIN = -(1 << (W-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, f, h;
  logic [3:0]    fs;
  logic [SW-1:0] sh;
  logic          c, n, v, z;

  logic          in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]   a16, b16, f16, h16;
  logic [3:0]    fs16;
  logic [3:0]    sh16;
  logic          c16, n16, v16, z16;

  alu_mc #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .FS(fs), .sh(sh), .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .H(h), .C(c), .N(n), .V(v), .Z(z)
  );

  alu_mc #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .FS(fs16), .sh(sh16), .out_valid(out_valid16), .out_ready(out_ready16),
    .F(f16), .H(h16), .C(c16), .N(n16), .V(v16), .Z(z16)
  );

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] h;
    logic         c, n, v, z;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   bp_hold  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int s);
    exp_t            e;
    int              sx, sy, r;
    longint unsigned p;
    sx = $signed(x);
    sy = $signed(y);
    e.f = '0; e.h = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'd1: begin
        r = int'(x) + int'(y);
        e.f = W'(r);
        e.c = (r >= (1 << W));
        r = sx + sy;
        e.v = (r > SMAX) || (r < SMIN);
      end
      4'd2: begin
        e.f = W'(int'(x) - int'(y));
        e.c = (x >= y);
        r = sx - sy;
        e.v = (r > SMAX) || (r < SMIN);
      end
      4'd3:        e.f = x ^ y;
      4'd4:        e.f = x | y;
      4'd7, 4'd12: e.f = ~x;
      4'd8:        e.f = x;
      4'd9:        e.f = x & y;
      4'd10:       e.f = (x > y) ? W'(1) : W'(0);
      4'd11:       e.f = (x == y) ? W'(1) : W'(0);
      4'd5: begin
        e.f = x >> s;
        e.c = (s > 0) ? x[s-1] : 1'b0;
        e.lat = (s > 0) ? s : 1;
      end
      4'd6: begin
        e.f = x << s;
        e.c = (s > 0) ? x[W-s] : 1'b0;
        e.lat = (s > 0) ? s : 1;
      end
      4'd14: begin
        e.f = W'($signed(x) >>> s);
        e.c = (s > 0) ? x[s-1] : 1'b0;
        e.lat = (s > 0) ? s : 1;
      end
      4'd13: begin
        p = longint'(x) * longint'(y);
        e.f = W'(p);
        e.h = W'(p >> W);
        e.c = (e.h != 0);
        e.v = e.c;
        e.lat = W;
      end
      default: ;
    endcase
    e.n = e.f[W-1];
    e.z = (e.f == 0) && (e.h == 0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic [SW-1:0] s);
    exp_t e;
    int   k;
    e = model(op, x, y, int'(s));
    @(negedge clk);
    in_valid = 1'b1; fs = op; a = x; b = y; sh = s;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
    end else begin
      e.acc = cyc;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      // keep a junk request on the bus while busy; it must be ignored
      in_valid = 1'($urandom_range(0, 1));
      fs = 4'($urandom); a = W'($urandom); b = W'($urandom); sh = SW'($urandom);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(SMAX);
      3:       return W'(1 << (W-1));
      default: return W'($urandom);
    endcase
  endfunction

  // monitor: pops the scoreboard on each new result, checks hold while stalled
  initial begin
    exp_t e, held;
    logic seen;
    seen = 1'b0;
    out_ready = 1'b1;
    held.f = '0; held.h = '0; held.c = 0; held.n = 0; held.v = 0; held.z = 0; held.lat = 0; held.acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk("F", 64'(f), 64'(e.f));
            chk("H", 64'(h), 64'(e.h));
            chk("flags_CNVZ", 64'({c, n, v, z}), 64'({e.c, e.n, e.v, e.z}));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            held = e;
            seen = 1'b1;
          end
        end else begin
          chk("hold_F_H", 64'({h, f}), 64'({held.h, held.f}));
          chk("hold_flags", 64'({c, n, v, z}), 64'({held.c, held.n, held.v, held.z}));
        end
        chk("in_ready_in_done", 64'(in_ready), 64'(0));
        if (bp_hold > 0) begin
          out_ready = 1'b0;
          bp_hold--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) seen = 1'b0;
      end else begin
        seen = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    int acc16, k;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; fs = '0; sh = '0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; fs16 = '0; sh16 = '0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_F_H", 64'({h, f}), 64'(0));
    chk("reset_flags", 64'({c, n, v, z}), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // 16-bit multiply latency and full product
    @(negedge clk);
    chk("mul16_ready", 64'(in_ready16), 64'(1));
    in_valid16 = 1'b1; fs16 = 4'd13; a16 = 16'hFFFF; b16 = 16'h0003;
    acc16 = cyc;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid16 && k < 100);
    chk("mul16_valid", 64'(out_valid16), 64'(1));
    chk("mul16_latency", 64'(cyc - acc16), 64'(16));
    chk("mul16_product", 64'({h16, f16}), 64'(32'(a16) * 32'(b16)));

    issue(4'd1,  8'h7F, 8'h01, 3'd0);
    issue(4'd2,  8'h05, 8'h05, 3'd0);
    issue(4'd14, 8'h86, 8'h00, 3'd2);
    issue(4'd6,  8'h81, 8'h00, 3'd0);
    issue(4'd13, 8'hFF, 8'h02, 3'd0);
    issue(4'd0,  8'h12, 8'h34, 3'd0);
    issue(4'd15, 8'hAB, 8'hCD, 3'd0);
    issue(4'd5,  8'h80, 8'h00, 3'd7);
    issue(4'd14, 8'h80, 8'h00, 3'd7);
    issue(4'd6,  8'h01, 8'h00, 3'd7);

    // backpressure: a new request waits while the result is held
    bp_hold = 5;
    issue(4'd3, 8'hAA, 8'h55, 3'd0);
    issue(4'd1, 8'h10, 8'h20, 3'd0);

    // reset in the middle of a multiply
    issue(4'd13, 8'hC3, 8'h5A, 3'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    chk("abort_F_H", 64'({h, f}), 64'(0));
    chk("abort_flags", 64'({c, n, v, z}), 64'(0));
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_abort", 64'(in_ready), 64'(1));
    issue(4'd1, 8'h01, 8'h01, 3'd0);

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), SW'($urandom));
    end

    in_valid = 1'b0;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand/result width; legal values are powers of two, 4 to 64.
REQ-002 The module SHALL have derived parameter SHW, default $clog2(WIDTH), meaning the shift-amount width.
REQ-003 clk  input  1  The single clock; all state changes on the rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 in_valid  input  1  The request is present.
REQ-006 in_ready  output  1  The block accepts a request this cycle.
REQ-007 A, B  input  WIDTH  The operands.
REQ-008 FS  input  4  The function select.
REQ-009 sh  input  SHW  The shift amount.
REQ-010 out_valid  output  1  The result and flags are valid.
REQ-011 out_ready  input  1  The consumer takes the result.
REQ-012 F  output  WIDTH  The result, low half of the product for MUL.
REQ-013 H  output  WIDTH  The high half of the product for MUL; 0 for all other operations.
REQ-014 C, N, V, Z  output  1  The carry, negative, overflow and zero flags, all registered.

Function
REQ-015 FS encoding SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 SHR, 6 SHL, 7 CPL, 8 PASS, 9 AND, 10 GT, 11 EQ, 12 NOT, 13 MUL, 14 ASR, 15 reserved.
REQ-016 NOP and reserved codes SHALL produce F=0 and H=0, with Z=1 and all other flags 0.
REQ-017 The FSM SHALL have states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE with rst low.
REQ-018 A request SHALL be accepted on an edge with in_valid&in_ready, and A, B, FS and sh SHALL be captured on that edge.
REQ-019 Requests presented outside IDLE SHALL be ignored.
REQ-020 Single-cycle operations (all codes except 5, 6, 13, 14) SHALL go IDLE->DONE with out_valid high on the cycle after acceptance.
REQ-021 Shifts SHALL go IDLE->EXEC and move one bit per cycle; sh=0 SHALL go directly to DONE; total latency SHALL be max(1, sh) cycles from acceptance to out_valid.
REQ-022 MUL SHALL be unsigned shift-add, one partial product per cycle, with out_valid WIDTH cycles after acceptance and {H,F} equal to the full 2*WIDTH-bit product.
REQ-023 In DONE, F, H, flags and out_valid SHALL hold until out_ready=1, then the FSM SHALL return to IDLE on the next edge; throughput SHALL be at most one operation per two cycles.
REQ-024 ADD/SUB SHALL compute at WIDTH+1 bits, with SUB as A+~B+1; C SHALL be the carry-out (for SUB, C=1 means no borrow, A>=B); V SHALL be two's-complement signed overflow.
REQ-025 SHR/SHL SHALL be zero-filling and ASR SHALL replicate A[WIDTH-1]; C SHALL be the last bit shifted out, or 0 when sh=0.
REQ-026 For MUL, C=V=(H!=0).
REQ-027 GT SHALL give F=1 if A>B unsigned, else 0; EQ SHALL give F=1 if A==B, else 0.
REQ-028 CPL and NOT SHALL both give F=~A; PASS SHALL give F=A.
REQ-029 For logic, compare, PASS and NOT operations, C=V=0.
REQ-030 N SHALL be F[WIDTH-1] for all operations.
REQ-031 Z SHALL be (F==0) for all operations except MUL, where it SHALL be ({H,F}==0).
REQ-032 Flags SHALL never carry over from a previous operation.

Reset
REQ-033 While rst is high, the state SHALL be IDLE, with in_ready=0, out_valid=0, F=H=0 and C=N=V=Z=0.
REQ-034 rst asserted during EXEC or DONE SHALL abort the operation immediately, with no out_valid for it.
REQ-035 After rst is released, in_ready SHALL be 1 on the first cycle.

Verification
REQ-036 Scenario ADD (WIDTH=8): A=7F, B=01, FS=1 -> next cycle F=80, N=1, V=1, C=0, Z=0, out_valid=1.
REQ-037 Scenario SUB (WIDTH=8): A=05, B=05, FS=2 -> F=00, Z=1, C=1, V=0, N=0.
REQ-038 Scenario ASR (WIDTH=8): A=86, sh=2, FS=14 -> out_valid 2 cycles after acceptance, F=E1, C=1, N=1; SHL with A=81, sh=0 -> 1 cycle, F=81, C=0.
REQ-039 Scenario MUL (WIDTH=8): A=FF, B=02, FS=13 -> out_valid 8 cycles after acceptance, H=01, F=FE, C=V=1, Z=0; with WIDTH=16, latency SHALL be 16.
REQ-040 Scenario backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> F and flags stable, in_ready=0, new request not taken; accepted only after out_ready=1 and return to IDLE.
REQ-041 Scenario reset mid-MUL: rst pulsed 3 cycles after acceptance -> outputs 0 immediately, no out_valid, next ADD A=01, B=01 -> F=02.
